fpu_result_scoreboard: RTL

- Response-side counterpart of the stimulus generator in the FPU verification top.
- Every issued operation and its golden result enter an in-order expected-results FIFO. Later FPU results are popped and compared against that FIFO.
- Keeps saturating pass/fail counts and flags protocol errors (overflow, underflow, timeout).
- Runs an end-of-test drain state machine so the bench knows when every outstanding result has been checked.

---
 rtl/fpu_tb_pkg.sv | 34 +++
 rtl/scb_fifo.sv | 56 +++++
 rtl/fpu_result_scoreboard.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fpu_tb_pkg.sv
// Shared types for the FPU verification top: opcodes, expected-result entries,
// scoreboard states and a NaN classifier.
package fpu_tb_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4,
    OP_MIN  = 3'd5,
    OP_MAX  = 3'd6,
    OP_CMP  = 3'd7
  } fpu_op_e;

  typedef struct packed {
    fpu_op_e     op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] golden;
  } exp_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scb_state_e;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/scb_fifo.sv
// In-order FIFO of expected-result entries; the head is presented combinationally.
module scb_fifo
  import fpu_tb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  exp_entry_t    wdata,
  input  logic          pop,
  output exp_entry_t    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  exp_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array is deliberately not reset; pointers and count alone
  // say which entries are valid, so the array can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fpu_result_scoreboard.sv
// Compares FPU results in order against golden values, keeps pass/fail counts,
// sticky protocol errors and an end-of-test drain FSM.
module fpu_result_scoreboard
  import fpu_tb_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       issue_valid,
  input  logic [2:0]                 issue_op,
  input  logic [31:0]                issue_opa,
  input  logic [31:0]                issue_opb,
  input  logic [31:0]                issue_golden,
  output logic                       issue_ready,
  input  logic                       res_valid,
  input  logic [31:0]                res_data,
  input  logic                       nan_equiv,
  input  logic                       drain_req,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       mismatch_valid,
  output logic [2:0]                 mismatch_op,
  output logic [31:0]                mismatch_opa,
  output logic [31:0]                mismatch_opb,
  output logic [31:0]                mismatch_exp,
  output logic [31:0]                mismatch_got,
  output logic                       err_overflow,
  output logic                       err_underflow,
  output logic                       err_timeout,
  output logic                       done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  scb_state_e    state_q, state_d;
  logic [TW-1:0] timeout_q, timeout_d, timeout_inc;
  logic          timeout_hit;

  exp_entry_t    wr_entry, head;
  logic          full, empty;
  logic [CW-1:0] count, pending_after;
  logic          accepting, push, res_fire, pop, match;

  logic [CNT_W-1:0] pass_q, fail_q;
  logic             mm_valid_q;
  exp_entry_t       mm_entry_q;
  logic [31:0]      mm_got_q;
  logic             ovf_q, udf_q, tmo_q;

  assign accepting   = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign issue_ready = !full && accepting;
  assign push        = issue_valid && issue_ready;
  // A result arriving while empty underflows even if an issue is pushed alongside.
  assign res_fire    = res_valid && (state_q != ST_DONE);
  assign pop         = res_fire && !empty;

  assign wr_entry = '{op: fpu_op_e'(issue_op), opa: issue_opa, opb: issue_opb,
                      golden: issue_golden};

  scb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .wdata  (wr_entry),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  assign match = (res_data == head.golden) ||
                 (nan_equiv && is_nan(res_data) && is_nan(head.golden));

  // Pushes never happen in DRAIN, so occupancy after this cycle is count - pop.
  assign pending_after = count - CW'(pop);
  assign timeout_inc   = timeout_q + TW'(1);
  assign timeout_hit   = !res_valid && (count != '0) && (timeout_inc == TW'(TIMEOUT));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    timeout_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (drain_req)  state_d = ST_DRAIN;
        else if (push)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (drain_req)  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!res_valid && (count != '0)) timeout_d = timeout_inc;
        if (pending_after == '0) state_d = ST_DONE;
        else if (timeout_hit)    state_d = ST_DONE;
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      timeout_q <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_q     <= '0;
      fail_q     <= '0;
      mm_valid_q <= 1'b0;
      mm_entry_q <= '0;
      mm_got_q   <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      mm_valid_q <= pop && !match;
      if (pop && match && !(&pass_q)) pass_q <= pass_q + CNT_W'(1);
      if (pop && !match) begin
        if (!(&fail_q)) fail_q <= fail_q + CNT_W'(1);
        mm_entry_q <= head;
        mm_got_q   <= res_data;
      end
      if (issue_valid && accepting && full) ovf_q <= 1'b1;
      if (res_fire && empty)                udf_q <= 1'b1;
      if ((state_q == ST_DRAIN) && (pending_after != '0) && timeout_hit) tmo_q <= 1'b1;
    end
  end

  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign pending        = count;
  assign mismatch_valid = mm_valid_q;
  assign mismatch_op    = mm_entry_q.op;
  assign mismatch_opa   = mm_entry_q.opa;
  assign mismatch_opb   = mm_entry_q.opb;
  assign mismatch_exp   = mm_entry_q.golden;
  assign mismatch_got   = mm_got_q;
  assign err_overflow   = ovf_q;
  assign err_underflow  = udf_q;
  assign err_timeout    = tmo_q;
  assign done           = (state_q == ST_DONE);

endmodule
